// File: rtl/stopwatch_ctrl_pkg.sv
// rtl/stopwatch_ctrl_pkg.sv - shared FSM encoding and default dividers for the stopwatch
package stopwatch_ctrl_pkg;

    localparam logic [1:0] ST_MANUAL    = 2'd0;
    localparam logic [1:0] ST_AUTO_IDLE = 2'd1;
    localparam logic [1:0] ST_AUTO_RUN  = 2'd2;

    localparam int DEF_TICK_DIV   = 1000;
    localparam int DEF_SCAN_DIV   = 1;
    localparam int DEF_BLINK_HALF = 500;

    // Counter width for a divide-by-n counter, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_edge_pulse.sv
// rtl/stopwatch_ctrl_edge_pulse.sv - rising-edge detector for one debounced button level
module edge_pulse (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    logic btn_q;
    logic btn_d;

    always_comb begin
        btn_d = btn;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_q <= 1'b0;
        end else begin
            btn_q <= btn_d;
        end
    end

    assign pulse = btn & ~btn_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch sequencing FSM, tick prescaler, digit scan and blink
module stopwatch_ctrl
    import stopwatch_ctrl_pkg::*;
#(
    parameter int TICK_DIV   = DEF_TICK_DIV,
    parameter int SCAN_DIV   = DEF_SCAN_DIV,
    parameter int BLINK_HALF = DEF_BLINK_HALF,
    parameter int WRAP       = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       mode,
    input  logic       at_max,
    output logic       count_en,
    output logic       count_clr,
    output logic [1:0] scan_sel,
    output logic [3:0] digit_en,
    output logic       blank,
    output logic       auto_mode,
    output logic       running,
    output logic       overflow
);

    localparam int TW = cnt_width(TICK_DIV);
    localparam int SW = cnt_width(SCAN_DIV);
    localparam int BW = cnt_width(BLINK_HALF);

    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

    logic start_p, stop_p, mode_p;

    edge_pulse u_start_edge (.clk(clk), .rst(rst), .btn(start), .pulse(start_p));
    edge_pulse u_stop_edge  (.clk(clk), .rst(rst), .btn(stop),  .pulse(stop_p));
    edge_pulse u_mode_edge  (.clk(clk), .rst(rst), .btn(mode),  .pulse(mode_p));

    // The first cycle after reset is masked so a button held through reset,
    // whose edge register restarts at 0, does not look like a fresh press.
    logic post_rst_q, post_rst_d;
    logic start_ev_q, start_ev_d;
    logic stop_ev_q,  stop_ev_d;
    logic mode_ev_q,  mode_ev_d;

    logic [1:0]    state_q, state_d;
    logic [TW-1:0] presc_q, presc_d;
    logic          count_en_q, count_en_d;
    logic          count_clr_q, count_clr_d;
    logic          overflow_q, overflow_d;
    logic [SW-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]    scan_sel_q, scan_sel_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          phase_q, phase_d;

    always_comb begin
        post_rst_d = 1'b0;
        start_ev_d = start_p & ~post_rst_q;
        stop_ev_d  = stop_p  & ~post_rst_q;
        mode_ev_d  = mode_p  & ~post_rst_q;
    end

    // Events are taken in strict priority stop > mode > start; lower ones are dropped.
    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        count_en_d  = 1'b0;
        count_clr_d = 1'b0;
        overflow_d  = overflow_q;
        case (state_q)
            ST_MANUAL: begin
                if (stop_ev_q) begin
                    count_clr_d = 1'b1;
                    overflow_d  = 1'b0;
                end else if (mode_ev_q) begin
                    state_d = ST_AUTO_IDLE;
                end else if (start_ev_q) begin
                    if (at_max) begin
                        overflow_d = 1'b1;
                    end else begin
                        count_en_d = 1'b1;
                    end
                end
            end
            ST_AUTO_IDLE: begin
                if (stop_ev_q) begin
                    count_clr_d = 1'b1;
                    overflow_d  = 1'b0;
                end else if (mode_ev_q) begin
                    state_d = ST_MANUAL;
                end else if (start_ev_q) begin
                    state_d = ST_AUTO_RUN;
                    presc_d = '0;
                end
            end
            ST_AUTO_RUN: begin
                if (stop_ev_q) begin
                    state_d = ST_AUTO_IDLE;
                    presc_d = '0;
                end else if (presc_q == TICK_LAST) begin
                    presc_d = '0;
                    if (at_max) begin
                        overflow_d = 1'b1;
                        if (WRAP != 0) begin
                            count_en_d = 1'b1;
                        end else begin
                            state_d = ST_AUTO_IDLE;
                        end
                    end else begin
                        count_en_d = 1'b1;
                    end
                end else begin
                    presc_d = presc_q + TW'(1);
                end
            end
            default: begin
                state_d = ST_MANUAL;
                presc_d = '0;
            end
        endcase
    end

    always_comb begin
        scan_cnt_d  = scan_cnt_q + SW'(1);
        scan_sel_d  = scan_sel_q;
        blink_cnt_d = blink_cnt_q + BW'(1);
        phase_d     = phase_q;
        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = '0;
            scan_sel_d = scan_sel_q + 2'd1;
        end
        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            post_rst_q  <= 1'b1;
            start_ev_q  <= 1'b0;
            stop_ev_q   <= 1'b0;
            mode_ev_q   <= 1'b0;
            state_q     <= ST_MANUAL;
            presc_q     <= '0;
            count_en_q  <= 1'b0;
            count_clr_q <= 1'b0;
            overflow_q  <= 1'b0;
            scan_cnt_q  <= '0;
            scan_sel_q  <= 2'd0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            post_rst_q  <= post_rst_d;
            start_ev_q  <= start_ev_d;
            stop_ev_q   <= stop_ev_d;
            mode_ev_q   <= mode_ev_d;
            state_q     <= state_d;
            presc_q     <= presc_d;
            count_en_q  <= count_en_d;
            count_clr_q <= count_clr_d;
            overflow_q  <= overflow_d;
            scan_cnt_q  <= scan_cnt_d;
            scan_sel_q  <= scan_sel_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end

    assign count_en  = count_en_q;
    assign count_clr = count_clr_q;
    assign overflow  = overflow_q;
    assign scan_sel  = scan_sel_q;
    assign blank     = phase_q & (state_q != ST_AUTO_RUN);
    assign digit_en  = blank ? 4'b0000 : (4'b0001 << scan_sel_q);
    assign auto_mode = (state_q == ST_AUTO_IDLE) || (state_q == ST_AUTO_RUN);
    assign running   = (state_q == ST_AUTO_RUN);

endmodule
